// File: rtl/fetch_controller.sv
// Instruction fetch controller: single-entry fetch slot fed from a combinational instruction
// memory, with redirect, halt/resume and an absorbing fault state for illegal addresses.
module fetch_controller #(
    parameter logic [31:0] INIT_PC   = 32'h0000_3000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        resume,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = INIT_PC + 32'(4 * MEM_WORDS) - 32'd4;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHalt  = 2'd1,
        StFault = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] count_q, count_d;

    logic slot_free;
    logic xfer;
    logic pc_legal;
    logic redir_legal;
    logic do_fetch;

    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= INIT_PC) && (addr <= LAST_PC);
    endfunction

    assign slot_free   = !valid_q || if_ready;
    assign xfer        = valid_q && if_ready;
    assign pc_legal    = addr_legal(pc_q);
    assign redir_legal = addr_legal(redirect_pc);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        do_fetch   = 1'b0;

        if (state_q != StFault && redirect_valid) begin
            // Redirect always flushes the slot, even one being accepted this cycle.
            valid_d = 1'b0;
            if (redir_legal) begin
                pc_d = redirect_pc;
                if (state_q == StRun && halt_req) begin
                    state_d = StHalt;
                end
            end else begin
                state_d    = StFault;
                fault_pc_d = redirect_pc;
            end
        end else begin
            case (state_q)
                StRun: begin
                    if (halt_req) begin
                        state_d = StHalt;
                        if (xfer) begin
                            valid_d = 1'b0;
                        end
                    end else if (slot_free) begin
                        if (pc_legal) begin
                            do_fetch = 1'b1;
                        end else begin
                            state_d    = StFault;
                            fault_pc_d = pc_q;
                            valid_d    = 1'b0;
                        end
                    end
                end
                StHalt: begin
                    if (xfer) begin
                        valid_d = 1'b0;
                    end
                    if (resume && !halt_req) begin
                        state_d = StRun;
                    end
                end
                default: begin
                end
            endcase
        end

        if (do_fetch) begin
            if_pc_d    = pc_q;
            if_instr_d = imem_instr;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
            count_d    = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            pc_q       <= INIT_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= 32'd0;
            fault_pc_q <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign fault       = (state_q == StFault);
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed stimulus, a transaction-level reference model checked
// every cycle, and literal spot checks that pin the model.
module tb_fetch_controller;

    localparam logic [31:0] INIT_PC   = 32'h0000_3000;
    localparam int unsigned MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    fetch_controller #(
        .INIT_PC  (INIT_PC),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .resume        (resume),
        .fault         (fault),
        .fault_pc      (fault_pc),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory image: word i holds the value i; outside the image returns a marker.
    function automatic bit in_image(input logic [31:0] a);
        longint unsigned off;
        if (a[1:0] != 2'b00 || a < INIT_PC) return 1'b0;
        off = longint'(a) - longint'(INIT_PC);
        return (off / 4) < MEM_WORDS;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!in_image(a)) return 32'hDEAD_BEEF;
        return (a - INIT_PC) >> 2;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    // Reference model: mode 0 = running, 1 = halted, 2 = faulted.
    int          m_mode;
    logic [31:0] m_pc, m_slot_pc, m_slot_instr, m_fpc, m_cnt;
    bit          m_valid;
    bit          m_taken;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = INIT_PC; m_valid = 0;
            m_slot_pc = 0; m_slot_instr = 0; m_fpc = 0; m_cnt = 0;
        end else if (m_mode != 2) begin
            m_taken = m_valid && if_ready;
            if (redirect_valid) begin
                m_valid = 0;
                if (in_image(redirect_pc)) begin
                    m_pc = redirect_pc;
                    if (m_mode == 0 && halt_req) m_mode = 1;
                end else begin
                    m_mode = 2; m_fpc = redirect_pc;
                end
            end else if (m_mode == 1) begin
                if (m_taken) m_valid = 0;
                if (resume && !halt_req) m_mode = 0;
            end else if (halt_req) begin
                if (m_taken) m_valid = 0;
                m_mode = 1;
            end else if (!m_valid || if_ready) begin
                if (in_image(m_pc)) begin
                    m_slot_pc = m_pc; m_slot_instr = mem_word(m_pc); m_valid = 1;
                    m_pc = m_pc + 4; m_cnt = m_cnt + 1;
                end else begin
                    m_mode = 2; m_fpc = m_pc; m_valid = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt_req = 1'b0; resume = 1'b0; if_ready = 1'b1;
        step(2);
        check("reset_valid", {31'd0, if_valid}, 32'd0);
        check("reset_addr", imem_addr, INIT_PC);
        check("reset_count", fetch_count, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt_req = 1'b0; resume = 1'b0;
        step(1);
        chk_en = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    check("m_imem_addr", imem_addr, m_pc);
                    check("m_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
                    check("m_if_pc", if_pc, m_slot_pc);
                    check("m_if_instr", if_instr, m_slot_instr);
                    check("m_fault", {31'd0, fault}, {31'd0, m_mode == 2});
                    check("m_fault_pc", fault_pc, m_fpc);
                    check("m_fetch_count", fetch_count, m_cnt);
                end
            end
        join_none

        // Sequential stream with if_ready held high.
        do_reset();
        check("reset_if_pc", if_pc, 32'd0);
        step(1);
        check("seq0_pc", if_pc, 32'h3000); check("seq0_instr", if_instr, 32'd0);
        step(1);
        check("seq1_pc", if_pc, 32'h3004); check("seq1_instr", if_instr, 32'd1);
        step(1);
        check("seq2_pc", if_pc, 32'h3008); check("seq2_instr", if_instr, 32'd2);
        check("seq_count", fetch_count, 32'd3);

        // Backpressure holds the slot.
        do_reset();
        step(1);
        if_ready = 1'b0;
        step(3);
        check("bp_pc", if_pc, 32'h3000);
        check("bp_addr", imem_addr, 32'h3004);
        check("bp_count", fetch_count, 32'd1);
        if_ready = 1'b1;
        step(1);
        check("bp_next_pc", if_pc, 32'h3004);

        // Redirect flushes an unaccepted slot.
        step(1);
        if_ready = 1'b0;
        step(1);
        check("rd_held_pc", if_pc, 32'h3008);
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        step(1);
        check("rd_flush", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0; if_ready = 1'b1;
        step(1);
        check("rd_target_pc", if_pc, 32'h3100);
        check("rd_target_instr", if_instr, 32'h40);

        // Halt at pc 0x3010, drain, resume.
        do_reset();
        step(4);
        check("halt_pre_addr", imem_addr, 32'h3010);
        if_ready = 1'b0; halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        step(1);
        check("halt_held_valid", {31'd0, if_valid}, 32'd1);
        check("halt_held_pc", if_pc, 32'h300C);
        if_ready = 1'b1;
        step(2);
        check("halt_drained", {31'd0, if_valid}, 32'd0);
        check("halt_count", fetch_count, 32'd4);
        halt_req = 1'b1; resume = 1'b1;
        step(1);
        halt_req = 1'b0; resume = 1'b0;
        step(1);
        check("halt_both_stays", fetch_count, 32'd4);
        resume = 1'b1;
        step(1);
        resume = 1'b0;
        step(1);
        check("resume_pc", if_pc, 32'h3010);
        check("resume_count", fetch_count, 32'd5);

        // Misaligned and below-range redirects fault.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            step(2);
            redirect_valid = 1'b1;
            redirect_pc = (k == 0) ? 32'h3102 : 32'h2FFC;
            step(1);
            check("flt_fault", {31'd0, fault}, 32'd1);
            check("flt_pc", fault_pc, (k == 0) ? 32'h3102 : 32'h2FFC);
            check("flt_valid", {31'd0, if_valid}, 32'd0);
            redirect_pc = 32'h3100; resume = 1'b1; halt_req = 1'b1;
            step(3);
            redirect_valid = 1'b0; resume = 1'b0; halt_req = 1'b0;
            check("flt_absorb", {31'd0, fault}, 32'd1);
            check("flt_addr_frozen", imem_addr, 32'h3008);
        end

        // Last legal word fetches; the next attempt faults; reset recovers.
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h3FFC;
        step(1);
        redirect_valid = 1'b0;
        step(1);
        check("last_pc", if_pc, 32'h3FFC);
        check("last_instr", if_instr, 32'd1023);
        step(1);
        check("ovr_fault", {31'd0, fault}, 32'd1);
        check("ovr_fault_pc", fault_pc, 32'h4000);
        check("ovr_valid", {31'd0, if_valid}, 32'd0);
        do_reset();
        check("rec_pc", imem_addr, 32'h3000);
        step(1);
        check("rec_first", if_pc, 32'h3000);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter INIT_PC, default 32'h00003000, meaning the reset PC and the base address of instruction memory.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning the instruction-memory depth in 32-bit words; the legal range is INIT_PC .. INIT_PC+4*MEM_WORDS-4.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 imem_addr  out  32  fetch address to instruction memory; combinational copy of internal pc register.
REQ-006 imem_instr  in  32  instruction word returned combinationally by instruction memory for imem_addr.
REQ-007 if_valid  out  1  fetch slot holds a valid instruction.
REQ-008 if_ready  in  1  decode stage accepts slot this cycle.
REQ-009 if_pc  out  32  address of instruction in slot.
REQ-010 if_instr  out  32  instruction in slot.
REQ-011 redirect_valid  in  1  branch/jump/exception redirect request.
REQ-012 redirect_pc  in  32  redirect target.
REQ-013 halt_req  in  1  request to stop fetching.
REQ-014 resume  in  1  request to restart fetching from HALT.
REQ-015 fault  out  1  high while in FAULT state.
REQ-016 fault_pc  out  32  offending address latched on FAULT entry.
REQ-017 fetch_count  out  32  number of instructions loaded into slot since reset, wraps at 2^32.

Function
REQ-018 SHALL implement states RUN, HALT, FAULT; no other states.
REQ-019 Address legal SHALL mean word-aligned (bits[1:0]==0) and within the REQ-002 range; comparisons unsigned 32-bit.
REQ-020 Slot free SHALL mean (!if_valid || if_ready); a transfer occurs on if_valid && if_ready.
REQ-021 Fetch SHALL occur in a cycle iff state==RUN, slot free, redirect_valid==0, halt_req==0, pc legal.
REQ-022 On fetch: if_pc<=pc, if_instr<=imem_instr, if_valid<=1, pc<=pc+4 (32-bit wrap), fetch_count<=fetch_count+1; latency one cycle from pc to slot.
REQ-023 On transfer without fetch, if_valid<=0; if_pc/if_instr hold.
REQ-024 While if_valid && !if_ready, if_pc/if_instr/if_valid SHALL hold unchanged unless a redirect or FAULT entry occurs.
REQ-025 Priority SHALL be: FAULT (absorbing) > redirect > halt_req > fetch.
REQ-026 Redirect in RUN or HALT with legal redirect_pc: pc<=redirect_pc, if_valid<=0 (flush regardless of if_ready), state unchanged except REQ-027 applies the same cycle.
REQ-027 halt_req in RUN: state<=HALT next cycle, no fetch that cycle; held slot stays valid until transferred.
REQ-028 In HALT: no fetch; resume && !halt_req SHALL set state<=RUN; first fetch no earlier than next cycle.
REQ-029 Redirect with illegal redirect_pc: state<=FAULT, fault_pc<=redirect_pc, if_valid<=0, pc unchanged.
REQ-030 In RUN with slot free, no redirect, no halt_req, and pc illegal (e.g. sequential overrun to INIT_PC+4*MEM_WORDS): state<=FAULT, fault_pc<=pc, if_valid<=0.
REQ-031 FAULT SHALL ignore redirect_valid, halt_req, resume, if_ready; exit only via reset.
REQ-032 fault SHALL be a decode of state==FAULT, asserted the cycle after entry.
REQ-033 Last legal word (INIT_PC+4*MEM_WORDS-4) SHALL fetch normally; fault arises only on the following fetch attempt.

Reset
REQ-034 While rst_n==0 at a rising edge: pc<=INIT_PC, state<=RUN, if_valid<=0, if_pc<=0, if_instr<=0, fault_pc<=0, fetch_count<=0.
REQ-035 Reset SHALL override all other inputs, including mid-redirect, mid-HALT and FAULT.
REQ-036 First fetch (pc=INIT_PC) SHALL occur on the first rising edge with rst_n==1.

Verification
REQ-037 Reset release, if_ready=1 constant, memory word i = i -> slot shows (0x3000,0),(0x3004,1),(0x3008,2) on consecutive cycles; fetch_count=3.
REQ-038 if_ready=0 for 3 cycles after first fetch -> if_pc stays 0x3000, imem_addr stays 0x3004, fetch_count stays 1; on if_ready=1 next slot is 0x3004.
REQ-039 redirect_pc=0x3100 while slot holds 0x3008 unaccepted -> next cycle if_valid=0, then slot shows 0x3100.
REQ-040 redirect_pc=0x3102, then separately 0x2FFC -> FAULT, fault_pc=0x3102 (resp. 0x2FFC), if_valid=0; redirect_valid, resume ignored until rst_n=0.
REQ-041 halt_req one cycle at pc=0x3010 -> no further fetch, held slot drains, fetch_count frozen; resume -> fetch resumes at 0x3010; halt_req and resume both high -> remains HALT.
REQ-042 Redirect to 0x3FFC, if_ready=1 -> slot 0x3FFC fetched, next cycle FAULT with fault_pc=0x4000; rst_n=0 one cycle -> RUN, pc=0x3000, fetch_count=0.
